// File: rtl/compare_serial_seq_if.sv
// Handshake and operand/result bundle for the digit-serial comparator.
// The master side issues requests; the slave side is the comparator.
interface compare_serial_seq_if #(
  parameter int WORD_SIZE = 32
);
  logic                 start;
  logic                 signed_mode;
  logic [WORD_SIZE-1:0] A;
  logic [WORD_SIZE-1:0] B;
  logic                 busy;
  logic                 done;
  logic                 A_lt_B;
  logic                 A_gt_B;
  logic                 A_eq_B;

  modport master (
    output start, signed_mode, A, B,
    input  busy, done, A_lt_B, A_gt_B, A_eq_B
  );

  modport slave (
    input  start, signed_mode, A, B,
    output busy, done, A_lt_B, A_gt_B, A_eq_B
  );
endinterface

// File: rtl/compare_serial_seq.sv
// Digit-serial magnitude comparator: examines DIGIT bits per cycle, MSB digit first,
// and stops at the first differing digit. Signed mode biases the sign bits at capture.
module compare_serial_seq #(
  parameter int WORD_SIZE = 32,
  parameter int DIGIT     = 4
) (
  input  logic                clk,
  input  logic                rst,
  compare_serial_seq_if.slave bus
);

  localparam int N    = WORD_SIZE / DIGIT;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDXW-1:0]      IDX_TOP  = IDXW'(N - 1);
  localparam logic [IDXW-1:0]      IDX_ZERO = IDXW'(0);
  localparam logic [IDXW-1:0]      IDX_ONE  = IDXW'(1);
  localparam logic [WORD_SIZE-1:0] MSB_MASK = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [DIGIT-1:0] digit_at(
    input logic [WORD_SIZE-1:0] word,
    input logic [IDXW-1:0]      idx
  );
    return word[int'(idx)*DIGIT +: DIGIT];
  endfunction

  state_t                state_q, state_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [WORD_SIZE-1:0]  a_q, a_d;
  logic [WORD_SIZE-1:0]  b_q, b_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  lt_q, lt_d;
  logic                  gt_q, gt_d;
  logic                  eq_q, eq_d;
  logic [DIGIT-1:0]      a_dig_s;
  logic [DIGIT-1:0]      b_dig_s;
  logic [WORD_SIZE-1:0]  flip_s;

  // Next-state, capture and result logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    a_dig_s = digit_at(a_q, idx_q);
    b_dig_s = digit_at(b_q, idx_q);
    // Inverting both sign bits makes an unsigned compare yield two's-complement order.
    flip_s  = bus.signed_mode ? MSB_MASK : {WORD_SIZE{1'b0}};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.A ^ flip_s;
          b_d     = bus.B ^ flip_s;
          idx_d   = IDX_TOP;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          busy_d  = 1'b0;
        end
      end
      RUN: begin
        if (a_dig_s != b_dig_s) begin
          gt_d    = (a_dig_s > b_dig_s);
          lt_d    = (a_dig_s < b_dig_s);
          eq_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (idx_q == IDX_ZERO) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q - IDX_ONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= {WORD_SIZE{1'b0}};
      b_q     <= {WORD_SIZE{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.A_lt_B = lt_q;
  assign bus.A_gt_B = gt_q;
  assign bus.A_eq_B = eq_q;

endmodule

// File: tb/tb_compare_serial_seq.sv
// Self-checking bench for compare_serial_seq: directed corner cases plus randomized
// compares against a word-level reference (native compare, latency from first differing bit).
module tb_compare_serial_seq;

  localparam int W = 32;
  localparam int D = 4;
  localparam int N = W / D;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  compare_serial_seq_if #(.WORD_SIZE(W)) bus ();

  compare_serial_seq #(.WORD_SIZE(W), .DIGIT(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of digits examined: stop at the digit holding the highest differing bit.
  function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x;
    x = a ^ b;
    for (int i = W - 1; i >= 0; i--) begin
      if (x[i]) return N - (i / D);
    end
    return N;
  endfunction

  // Expected {lt, gt, eq} from a plain word compare.
  function automatic logic [2:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sm);
    logic lt, gt;
    if (sm) begin
      lt = ($signed(a) < $signed(b));
      gt = ($signed(a) > $signed(b));
    end else begin
      lt = (a < b);
      gt = (a > b);
    end
    return {lt, gt, (a == b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] res_now();
    return {bus.A_lt_B, bus.A_gt_B, bus.A_eq_B};
  endfunction

  task automatic sample_start();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
    bus.A           = a;
    bus.B           = b;
    bus.signed_mode = sm;
    bus.start       = 1'b1;
    sample_start();
  endtask

  // Called just after the edge that sampled start; follows the compare to its done cycle.
  task automatic expect_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                            input string tag, input int poke_at, input bit hold,
                            input logic [W-1:0] na, input logic [W-1:0] nb, input logic nsm);
    int         k;
    logic [2:0] r;
    k = ref_lat(a, b);
    r = ref_res(a, b, sm);
    for (int c = 0; c <= k; c++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'(c < k));
      chk({tag, "_done"}, 32'(bus.done), 32'(c == k));
      if (c == k) begin
        chk({tag, "_res"}, 32'(res_now()), 32'(r));
        if (hold) begin
          bus.A           = na;
          bus.B           = nb;
          bus.signed_mode = nsm;
          bus.start       = 1'b1;
        end else begin
          bus.start       = 1'b0;
        end
      end else begin
        bus.start       = (c == poke_at);
        bus.A           = $urandom;
        bus.B           = $urandom;
        bus.signed_mode = 1'($urandom_range(1, 0));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle_check(input string tag, input logic [2:0] held);
    @(posedge clk);
    #1;
    chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
    chk({tag, "_hold"}, 32'(res_now()), 32'(held));
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input string tag);
    launch(a, b, sm);
    expect_run(a, b, sm, tag, -1, 1'b0, '0, '0, 1'b0);
    idle_check(tag, ref_res(a, b, sm));
  endtask

  initial begin
    logic [W-1:0] ca, cb, na, nb;
    logic         cs, ns;
    bit           chain;
    tests           = 0;
    failed          = 0;
    rst             = 1'b1;
    bus.start       = 1'b1;
    bus.signed_mode = 1'b0;
    bus.A           = 32'h0000_0001;
    bus.B           = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_done", 32'(bus.done), 32'd0);
    chk("reset_res", 32'(res_now()), 32'd0);
    bus.start = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_idle", 32'(bus.busy), 32'd0);

    run_one(32'h1234_5678, 32'h1234_5678, 1'b0, "eq_full");
    run_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, "msb_unsigned");
    run_one(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, "msb_signed");
    run_one(32'h0000_0100, 32'h0000_0000, 1'b0, "gt_digit2");
    run_one(32'h0000_0010, 32'h0000_0011, 1'b0, "lt_digit0");
    run_one(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, "neg_one");

    // Start pulsed mid-compare is ignored; start held on the done cycle chains a new compare.
    launch(32'h1234_5678, 32'h1234_5678, 1'b0);
    expect_run(32'h1234_5678, 32'h1234_5678, 1'b0, "ignore_start", 2, 1'b1,
               32'h0000_0100, 32'h0000_0000, 1'b0);
    sample_start();
    expect_run(32'h0000_0100, 32'h0000_0000, 1'b0, "b2b", -1, 1'b0, '0, '0, 1'b0);
    idle_check("b2b", 3'b010);

    // Reset three cycles into a full-length compare.
    launch(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_reset_busy", 32'(bus.busy), 32'd0);
    chk("mid_reset_done", 32'(bus.done), 32'd0);
    chk("mid_reset_res", 32'(res_now()), 32'd0);
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      #1;
      chk("no_done_after_reset", 32'(bus.done), 32'd0);
    end
    run_one(32'h0000_0005, 32'h0000_0009, 1'b0, "after_reset");

    // Randomized compares with a mix of latencies, signedness and chaining.
    ca = $urandom;
    cb = ca ^ (32'd1 << $urandom_range(31, 0));
    cs = 1'($urandom_range(1, 0));
    launch(ca, cb, cs);
    for (int i = 0; i < 60; i++) begin
      na = $urandom;
      case ($urandom_range(2, 0))
        0:       nb = $urandom;
        1:       nb = na;
        default: nb = na ^ (32'd1 << $urandom_range(31, 0));
      endcase
      ns    = 1'($urandom_range(1, 0));
      chain = (i < 59) && ($urandom_range(1, 0) == 1);
      expect_run(ca, cb, cs, "rand", -1, chain, na, nb, ns);
      if (chain) begin
        sample_start();
      end else begin
        idle_check("rand", ref_res(ca, cb, cs));
        if (i < 59) launch(na, nb, ns);
      end
      ca = na;
      cb = nb;
      cs = ns;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
